// File: rtl/axis_ramp_scaler_if.sv
// AXI4-Stream bundle used on both sides of the ramp scaler.
// Latency: none (signal bundle only).
// Backpressure: TREADY flows from slave to master; a beat transfers when TVALID & TREADY.
//
// Signals:
//   TDATA  - sample lanes, 16 bits each
//   TSTRB  - byte strobes (master side only)
//   TLAST  - packet delimiter (master side only)
//   TVALID - beat valid, driven by the master
//   TREADY - beat accepted, driven by the slave
interface axis_ramp_scaler_if #(
  parameter int W = 256
);
  logic [W-1:0]   TDATA;
  logic [W/8-1:0] TSTRB;
  logic           TLAST;
  logic           TVALID;
  logic           TREADY;

  modport master (
    output TDATA,
    output TSTRB,
    output TLAST,
    output TVALID,
    input  TREADY
  );

  // The upstream ramp generator carries no framing, so only data/valid/ready
  // are seen by the scaler's input.
  modport slave (
    input  TDATA,
    input  TVALID,
    output TREADY
  );
endinterface

// File: rtl/axis_ramp_scaler.sv
// Converts offset-binary ramp samples to two's complement, scales by a Q2.15 gain
// with round-half-up and saturation, and frames the output into fixed-length packets.
// Latency: 2 cycles input handshake to output valid; 1 beat/cycle sustained; any
// stall on M_AXIS.TREADY propagates back through a two-stage skid-free pipeline.
//
// Ports:
//   AXIS_ACLK    - clock for both stream sides
//   AXIS_ARESET  - asynchronous active-high reset
//   amplitude    - [16:0] unsigned Q2.15 gain, sampled on the first beat of each packet
//   S_AXIS       - input stream (slave modport)
//   M_AXIS       - output stream (master modport), TLAST every BEATS_PER_PACKET beats
//   packet_count - completed output packets, wraps modulo 2^32
module axis_ramp_scaler #(
  parameter int C_AXIS_TDATA_WIDTH = 256,
  parameter int BEATS_PER_PACKET   = 256,
  parameter bit OFFSET_BINARY_IN   = 1'b1
) (
  input  logic                       AXIS_ACLK,
  input  logic                       AXIS_ARESET,
  input  logic [31:0]                amplitude,
  axis_ramp_scaler_if.slave          S_AXIS,
  axis_ramp_scaler_if.master         M_AXIS,
  output logic [31:0]                packet_count
);

  localparam int LANES = C_AXIS_TDATA_WIDTH / 16;
  localparam int CW    = (BEATS_PER_PACKET > 1) ? $clog2(BEATS_PER_PACKET) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS_PER_PACKET - 1);

  // Pipeline state
  logic                          r_v1;
  logic                          r_v2;
  logic                          r_last1;
  logic                          r_last2;
  logic signed [33:0]            r_p [LANES];
  logic [C_AXIS_TDATA_WIDTH-1:0] r_dat;
  logic [CW-1:0]                 r_in_cnt;
  logic [16:0]                   r_gain;
  logic [31:0]                   r_pkt_cnt;

  logic                          w_adv1;
  logic                          w_adv2;
  logic                          w_in_fire;
  logic                          w_out_fire;
  logic                          w_first;
  logic                          w_last_in;
  logic [16:0]                   w_gain;
  logic signed [33:0]            w_p [LANES];
  logic [C_AXIS_TDATA_WIDTH-1:0] w_sat;
  logic                          w_unused;

  assign w_unused = ^amplitude[31:17];

  // A stage may load when it is empty or its contents move on this cycle.
  assign w_adv2     = ~r_v2 | M_AXIS.TREADY;
  assign w_adv1     = ~r_v1 | w_adv2;
  assign w_in_fire  = S_AXIS.TVALID & w_adv1;
  assign w_out_fire = r_v2 & M_AXIS.TREADY;

  // The first beat of a packet uses the live amplitude so the gain it latches
  // applies to the whole packet, including that beat.
  assign w_first   = (r_in_cnt == '0);
  assign w_last_in = (r_in_cnt == LAST_CNT);
  assign w_gain    = w_first ? amplitude[16:0] : r_gain;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [15:0]        w_x;
    logic signed [15:0] w_s;
    logic signed [17:0] w_g;
    logic signed [33:0] w_sum;
    logic signed [18:0] w_r;

    assign w_x = S_AXIS.TDATA[16*i +: 16];
    assign w_s = OFFSET_BINARY_IN ? {~w_x[15], w_x[14:0]} : w_x;
    assign w_g = {1'b0, w_gain};
    // 16b signed x 18b signed (gain zero-extended) fits in 34 bits.
    assign w_p[i] = w_s * w_g;

    // Adding half an LSB then dropping 15 bits rounds half toward +inf;
    // the largest |p| leaves headroom in 34 bits for the addend.
    assign w_sum = r_p[i] + 34'sd16384;
    assign w_r   = w_sum[33:15];
    assign w_sat[16*i +: 16] = (w_r > 19'sd32767)  ? 16'h7FFF :
                               (w_r < -19'sd32768) ? 16'h8000 :
                                                     w_r[15:0];
  end

  // Input side: packet counter and per-packet gain
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      r_in_cnt <= '0;
      r_gain   <= 17'h08000;
    end else if (w_in_fire) begin
      r_in_cnt <= w_last_in ? '0 : r_in_cnt + CW'(1);
      if (w_first) r_gain <= amplitude[16:0];
    end
  end

  // S1: multiply
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      for (int i = 0; i < LANES; i++) r_p[i] <= '0;
    end else if (w_adv1) begin
      r_v1 <= S_AXIS.TVALID;
      if (S_AXIS.TVALID) begin
        r_last1 <= w_last_in;
        for (int i = 0; i < LANES; i++) r_p[i] <= w_p[i];
      end
    end
  end

  // S2: round/saturate into the output registers
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      r_dat   <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_dat   <= w_sat;
        r_last2 <= r_last1;
      end
    end
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      r_pkt_cnt <= '0;
    end else if (w_out_fire && r_last2) begin
      r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end

  assign S_AXIS.TREADY = w_adv1;
  assign M_AXIS.TDATA  = r_dat;
  assign M_AXIS.TLAST  = r_last2;
  assign M_AXIS.TVALID = r_v2;
  assign M_AXIS.TSTRB  = '1;
  assign packet_count  = r_pkt_cnt;

endmodule

// File: tb/tb_axis_ramp_scaler.sv
// Self-checking bench for axis_ramp_scaler: directed arithmetic/framing cases
// plus randomized valid/ready traffic checked against a behavioural model.
// Timing: inputs change 1 time unit after posedge, DUT observed at negedge.
module tb_axis_ramp_scaler;

  localparam int W     = 256;
  localparam int LANES = W / 16;
  localparam int BPP   = 4;

  logic        clk;
  logic        rst;
  logic [31:0] amplitude;
  logic [31:0] pkt_cnt;
  int          cyc;

  axis_ramp_scaler_if #(.W(W)) s_if ();
  axis_ramp_scaler_if #(.W(W)) m_if ();

  axis_ramp_scaler #(
    .C_AXIS_TDATA_WIDTH (W),
    .BEATS_PER_PACKET   (BPP),
    .OFFSET_BINARY_IN   (1'b1)
  ) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESET  (rst),
    .amplitude    (amplitude),
    .S_AXIS       (s_if),
    .M_AXIS       (m_if),
    .packet_count (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] dat;
    logic         last;
  } beat_t;

  // Reference model state
  beat_t        exp_q[$];
  int           mdl_cnt;
  int           mdl_gain;
  int           mdl_pkts;
  int           n_in;
  int           n_out;
  logic         last_log[$];
  logic [15:0]  lane0_log[$];
  logic         stall_prev;
  logic [W-1:0] held_dat;
  logic         held_last;
  logic         rand_run;

  // Offset-binary sample -> value in [-32768, 32767], times gain/2^15,
  // rounded to nearest with ties upward, clamped to 16-bit signed.
  function automatic logic [15:0] ref_lane(input logic [15:0] x, input int g);
    longint s, p, t, r;
    s = longint'(x) - 32768;
    p = s * longint'(g);
    t = p + 16384;
    if (t >= 0) r = t / 32768;
    else        r = -((-t + 32767) / 32768);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d, input int g);
    logic [W-1:0] o;
    for (int i = 0; i < LANES; i++) o[16*i +: 16] = ref_lane(d[16*i +: 16], g);
    return o;
  endfunction

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  // Scoreboard / monitor
  always @(negedge clk) begin : mon
    beat_t e;
    if (!rst) begin
      if (stall_prev) begin
        n_vec++;
        if (m_if.TVALID !== 1'b1 || m_if.TDATA !== held_dat || m_if.TLAST !== held_last) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%b last=%b data=%h, required valid=1 last=%b data=%h",
                   m_if.TVALID, m_if.TLAST, m_if.TDATA, held_last, held_dat);
        end
      end
      if (m_if.TVALID && m_if.TREADY) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: got data=%h last=%b, required no beat", m_if.TDATA, m_if.TLAST);
        end else begin
          e = exp_q.pop_front();
          if (m_if.TDATA !== e.dat || m_if.TLAST !== e.last) begin
            n_err++;
            $display("FAIL out_beat %0d: got data=%h last=%b, required data=%h last=%b",
                     n_out, m_if.TDATA, m_if.TLAST, e.dat, e.last);
          end
        end
        last_log.push_back(m_if.TLAST);
        lane0_log.push_back(m_if.TDATA[15:0]);
        n_out++;
        if (m_if.TLAST) mdl_pkts++;
      end
      stall_prev = m_if.TVALID && !m_if.TREADY;
      held_dat   = m_if.TDATA;
      held_last  = m_if.TLAST;
      if (s_if.TVALID && s_if.TREADY) begin
        if (mdl_cnt == 0) mdl_gain = int'(amplitude[16:0]);
        e.dat  = ref_beat(s_if.TDATA, mdl_gain);
        e.last = (mdl_cnt == BPP - 1);
        exp_q.push_back(e);
        mdl_cnt = (mdl_cnt + 1) % BPP;
        n_in++;
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    last_log.delete();
    lane0_log.delete();
    mdl_cnt    = 0;
    mdl_pkts   = 0;
    n_in       = 0;
    n_out      = 0;
    stall_prev = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    s_if.TVALID = 1'b0;
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Presents one beat and returns 1 unit after the accepting edge.
  task automatic send_beat(input logic [W-1:0] d);
    int t;
    t = 0;
    s_if.TDATA  = d;
    s_if.TVALID = 1'b1;
    while (t < 200) begin
      @(negedge clk);
      if (s_if.TREADY) begin
        @(posedge clk); #1;
        s_if.TVALID = 1'b0;
        return;
      end
      @(posedge clk); #1;
      t++;
    end
    s_if.TVALID = 1'b0;
    n_vec++;
    n_err++;
    $display("FAIL send_timeout: got TREADY low for %0d cycles, required acceptance", t);
  endtask

  task automatic drain();
    int t;
    t = 0;
    m_if.TREADY = 1'b1;
    while ((exp_q.size() != 0 || m_if.TVALID) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [W/8-1:0] ones;
    ones = '1;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec += 6;
    if (m_if.TVALID !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b, required 0", m_if.TVALID); end
    if (m_if.TDATA !== '0) begin n_err++; $display("FAIL rst_tdata: got %h, required 0", m_if.TDATA); end
    if (m_if.TLAST !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b, required 0", m_if.TLAST); end
    if (pkt_cnt !== 32'd0) begin n_err++; $display("FAIL rst_pkt_cnt: got %0d, required 0", pkt_cnt); end
    if (s_if.TREADY !== 1'b1) begin n_err++; $display("FAIL rst_tready: got %b, required 1", s_if.TREADY); end
    if (m_if.TSTRB !== ones) begin n_err++; $display("FAIL rst_tstrb: got %h, required %h", m_if.TSTRB, ones); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_vec += 2;
    if (s_if.TREADY !== 1'b1) begin n_err++; $display("FAIL rel_tready: got %b, required 1", s_if.TREADY); end
    if (m_if.TVALID !== 1'b0) begin n_err++; $display("FAIL rel_tvalid: got %b, required 0", m_if.TVALID); end
    @(posedge clk); #1;
  endtask

  task automatic test_unity_latency();
    logic [W-1:0] d;
    apply_reset();
    amplitude   = 32'h0000_8000;
    m_if.TREADY = 1'b1;
    d = rand_data();
    d[15:0] = 16'h0000; d[31:16] = 16'h8000; d[47:32] = 16'hFFFC;
    send_beat(d);
    n_vec++;
    if (m_if.TVALID !== 1'b0) begin n_err++; $display("FAIL lat_early: got TVALID=%b one cycle after accept, required 0", m_if.TVALID); end
    @(posedge clk); #1;
    n_vec += 5;
    if (m_if.TVALID !== 1'b1) begin n_err++; $display("FAIL lat_2cyc: got TVALID=%b two cycles after accept, required 1", m_if.TVALID); end
    if (m_if.TDATA[15:0] !== 16'h8000) begin n_err++; $display("FAIL unity_l0: got %h, required 8000", m_if.TDATA[15:0]); end
    if (m_if.TDATA[31:16] !== 16'h0000) begin n_err++; $display("FAIL unity_l1: got %h, required 0000", m_if.TDATA[31:16]); end
    if (m_if.TDATA[47:32] !== 16'h7FFC) begin n_err++; $display("FAIL unity_l2: got %h, required 7ffc", m_if.TDATA[47:32]); end
    if (m_if.TLAST !== 1'b0) begin n_err++; $display("FAIL unity_last: got %b, required 0", m_if.TLAST); end
    drain();
  endtask

  task automatic test_saturation();
    logic [W-1:0] d;
    apply_reset();
    amplitude = 32'h0001_0000;
    d = rand_data();
    d[15:0] = 16'hC000; d[31:16] = 16'h3FFF;
    send_beat(d);
    @(posedge clk); #1;
    n_vec += 2;
    if (m_if.TDATA[15:0] !== 16'h7FFF) begin n_err++; $display("FAIL sat_pos: got %h, required 7fff", m_if.TDATA[15:0]); end
    if (m_if.TDATA[31:16] !== 16'h8000) begin n_err++; $display("FAIL sat_neg: got %h, required 8000", m_if.TDATA[31:16]); end
    drain();
  endtask

  task automatic test_rounding();
    logic [W-1:0] d;
    apply_reset();
    amplitude = 32'hABCC_4000; // upper bits must be ignored; gain = 0.5
    d = rand_data();
    d[15:0] = 16'h8003; d[31:16] = 16'h7FFD;
    send_beat(d);
    @(posedge clk); #1;
    n_vec += 2;
    if (m_if.TDATA[15:0] !== 16'h0002) begin n_err++; $display("FAIL round_pos: got %h, required 0002", m_if.TDATA[15:0]); end
    if (m_if.TDATA[31:16] !== 16'hFFFF) begin n_err++; $display("FAIL round_neg: got %h, required ffff", m_if.TDATA[31:16]); end
    drain();
  endtask

  task automatic test_framing();
    logic [W-1:0] d;
    int c0;
    apply_reset();
    amplitude   = 32'h0000_8000;
    m_if.TREADY = 1'b1;
    c0 = cyc;
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < LANES; i++) d[16*i +: 16] = 16'(16'h8000 + b * LANES + i);
      send_beat(d);
    end
    n_vec++;
    if (cyc - c0 !== 12) begin n_err++; $display("FAIL frame_rate: got %0d cycles for 12 beats, required 12", cyc - c0); end
    drain();
    n_vec += 2;
    if (last_log.size() !== 12) begin n_err++; $display("FAIL frame_count: got %0d beats, required 12", last_log.size()); end
    if (pkt_cnt !== 32'd3) begin n_err++; $display("FAIL frame_pkts: got %0d, required 3", pkt_cnt); end
    for (int k = 0; k < last_log.size(); k++) begin
      n_vec++;
      if (last_log[k] !== ((k % BPP) == BPP - 1)) begin
        n_err++;
        $display("FAIL frame_last beat %0d: got %b, required %b", k + 1, last_log[k], (k % BPP) == BPP - 1);
      end
    end
  endtask

  task automatic test_gain_change();
    logic [W-1:0] d;
    logic [15:0]  want;
    apply_reset();
    amplitude   = 32'h0000_8000;
    m_if.TREADY = 1'b1;
    for (int i = 0; i < LANES; i++) d[16*i +: 16] = 16'h9000; // +4096
    send_beat(d);
    amplitude = 32'h0000_4000;
    for (int b = 1; b < 8; b++) send_beat(d);
    drain();
    n_vec++;
    if (lane0_log.size() !== 8) begin n_err++; $display("FAIL gain_count: got %0d beats, required 8", lane0_log.size()); end
    for (int k = 0; k < lane0_log.size(); k++) begin
      want = (k < BPP) ? 16'h1000 : 16'h0800;
      n_vec++;
      if (lane0_log[k] !== want) begin
        n_err++;
        $display("FAIL gain_beat %0d: got %h, required %h", k + 1, lane0_log[k], want);
      end
    end
  endtask

  task automatic test_random_traffic();
    apply_reset();
    amplitude = 32'h0000_8000;
    rand_run  = 1'b1;
    fork
      begin
        for (int b = 0; b < 1000; b++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          if ($urandom_range(0, 7) == 0) amplitude = $urandom();
          send_beat(rand_data());
        end
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          m_if.TREADY = $urandom_range(0, 1) == 1;
          @(posedge clk); #1;
        end
      end
    join
    drain();
    n_vec += 3;
    if (n_in !== 1000 || n_out !== 1000) begin n_err++; $display("FAIL rand_counts: got in=%0d out=%0d, required 1000/1000", n_in, n_out); end
    if (pkt_cnt !== 32'd250) begin n_err++; $display("FAIL rand_pkts: got %0d, required 250", pkt_cnt); end
    if (pkt_cnt !== mdl_pkts) begin n_err++; $display("FAIL rand_pkts_seen: got %0d, required %0d", pkt_cnt, mdl_pkts); end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    amplitude   = 32'h0000_8000;
    m_if.TREADY = 1'b0;
    send_beat(rand_data());
    send_beat(rand_data());
    s_if.TDATA  = rand_data();
    s_if.TVALID = 1'b1;
    n_vec++;
    if (s_if.TREADY !== 1'b0) begin n_err++; $display("FAIL full_tready: got %b, required 0", s_if.TREADY); end
    #2 rst = 1'b1;
    s_if.TVALID = 1'b0;
    clear_model();
    #1;
    n_vec += 4;
    if (m_if.TVALID !== 1'b0) begin n_err++; $display("FAIL mid_rst_tvalid: got %b, required 0", m_if.TVALID); end
    if (m_if.TDATA !== '0) begin n_err++; $display("FAIL mid_rst_tdata: got %h, required 0", m_if.TDATA); end
    if (m_if.TLAST !== 1'b0) begin n_err++; $display("FAIL mid_rst_tlast: got %b, required 0", m_if.TLAST); end
    if (s_if.TREADY !== 1'b1) begin n_err++; $display("FAIL mid_rst_tready: got %b, required 1", s_if.TREADY); end
    @(posedge clk); #1;
    rst = 1'b0;
    amplitude   = 32'h0000_4000;
    m_if.TREADY = 1'b1;
    for (int b = 0; b < BPP; b++) send_beat(rand_data());
    drain();
    n_vec += 2;
    if (last_log.size() !== BPP) begin n_err++; $display("FAIL post_rst_count: got %0d beats, required %0d", last_log.size(), BPP); end
    if (pkt_cnt !== 32'd1) begin n_err++; $display("FAIL post_rst_pkts: got %0d, required 1", pkt_cnt); end
    for (int k = 0; k < last_log.size(); k++) begin
      n_vec++;
      if (last_log[k] !== (k == BPP - 1)) begin
        n_err++;
        $display("FAIL post_rst_last beat %0d: got %b, required %b", k + 1, last_log[k], k == BPP - 1);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_if.TDATA  = '0;
    s_if.TVALID = 1'b0;
    s_if.TLAST  = 1'b0;
    s_if.TSTRB  = '1;
    m_if.TREADY = 1'b1;
    amplitude   = 32'h0000_8000;
    rand_run    = 1'b0;
    mdl_gain    = 32'h8000;
    clear_model();

    test_reset();
    test_unity_latency();
    test_saturation();
    test_rounding();
    test_framing();
    test_gain_change();
    test_random_traffic();
    test_reset_mid_packet();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_ramp_scaler.md
Name: axis_ramp_scaler

Overview:
- Sits directly downstream of the ramp generator and upstream of the RF-DAC AXI4-Stream input.
- Takes 256-bit beats holding 16 × 16-bit offset-binary samples. Converts each sample to two's complement, applies a runtime amplitude gain with rounding and saturation, then outputs the scaled samples.
- Adds packet framing: TLAST is asserted every BEATS_PER_PACKET output beats.
- Applies gain changes only at packet boundaries, so a packet never mixes two gains.

Parameters:
- C_AXIS_TDATA_WIDTH, 256, stream width; must be a multiple of 16; lanes = width/16.
- BEATS_PER_PACKET, 256, beats per packet; range 1..65536.
- OFFSET_BINARY_IN, 1, when 1 the MSB of each input sample is inverted before scaling; when 0 input is already two's complement.

Ports:
- AXIS_ACLK  in  1  single clock for both stream interfaces.
- AXIS_ARESET  in  1  asynchronous, active-high reset.
- amplitude  in  32  bits [16:0] = unsigned gain, Q2.15 (0x08000 = 1.0, max ≈ 3.99997); bits [31:17] ignored.
- S_AXIS_TDATA  in  C_AXIS_TDATA_WIDTH  input samples; lane i = bits [16i+15:16i].
- S_AXIS_TVALID  in  1  input beat valid.
- S_AXIS_TREADY  out  1  input beat accepted when high together with S_AXIS_TVALID.
- M_AXIS_TDATA  out  C_AXIS_TDATA_WIDTH  scaled two's-complement samples, same lane order as input.
- M_AXIS_TSTRB  out  C_AXIS_TDATA_WIDTH/8  constant all-ones.
- M_AXIS_TLAST  out  1  high on the last beat of each packet.
- M_AXIS_TVALID  out  1  output beat valid.
- M_AXIS_TREADY  in  1  downstream ready.
- packet_count  out  32  number of completed output packets; wraps modulo 2^32.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - v1, v2 (stage valids) to 0, so M_AXIS_TVALID = 0 and S_AXIS_TREADY = 1 on reset release.
  - M_AXIS_TDATA to 0, M_AXIS_TLAST to 0, packet_count to 0.
  - in_cnt to 0, gain_r to 0x08000.
- Pipeline: two register stages, S1 (multiply) and S2 (round/saturate → output registers).
  - adv2 = ~v2 | M_AXIS_TREADY.
  - adv1 = ~v1 | adv2.
  - S_AXIS_TREADY = adv1 (combinational from registered state and M_AXIS_TREADY; no combinational path from S_AXIS_TVALID).
  - Input-to-output latency is 2 cycles with no backpressure. Sustained throughput is 1 beat/cycle.
  - No beat is dropped or duplicated under any TREADY pattern.
  - M_AXIS_TDATA/TLAST stay stable while M_AXIS_TVALID = 1 and M_AXIS_TREADY = 0.
- Input accept (S_AXIS_TVALID & S_AXIS_TREADY):
  - If in_cnt == 0, latch gain_r <= amplitude[16:0] and use that new gain for this beat.
  - Otherwise use gain_r.
  - last = (in_cnt == BEATS_PER_PACKET-1). in_cnt increments, wrapping to 0 after the last beat.
  - last travels with the beat through both stages.
- Per-lane arithmetic:
  - s = OFFSET_BINARY_IN ? {~x[15], x[14:0]} : x, interpreted as signed 16-bit.
  - p = s × gain, a signed 34-bit product with gain zero-extended.
  - r = (p + 2^14) >>> 15 (arithmetic shift; rounds half toward +∞).
  - Saturate r to [-32768, +32767].
- S1 registers p and last when adv1. S2 registers the saturated result and last when adv2.
- Lanes are independent with no cross-lane carry.
- packet_count increments on an output handshake where M_AXIS_TLAST = 1. Wrap from 0xFFFFFFFF to 0.
- BEATS_PER_PACKET = 1: every beat has TLAST = 1, and gain is re-latched every beat.
- Reset mid-packet: the partial packet is discarded, in_cnt restarts at 0, and the next accepted beat re-latches gain.
- A gain change mid-packet takes effect on the first beat of the next packet only.

Test Plan:
- Gain 0x08000, single beat, all lanes 0x0000/0x8000/0xFFFC (offset binary) → output 0x8000/0x0000/0x7FFC, M_AXIS_TVALID rises exactly 2 cycles after the input handshake.
- Gain 0x10000 (2.0), lanes 0xC000 and 0x3FFF → 0x7FFF (positive saturation) and 0x8000 (-32768, negative saturation, since 0xBFFF×2 = -32770).
- Gain 0x04000 (0.5), lanes 0x8003 (+3) and 0x7FFD (-3) → 0x0002 and 0xFFFF (rounding rule).
- BEATS_PER_PACKET = 4, continuous ramp input, M_AXIS_TREADY held 1 → TLAST on beats 4, 8, 12; packet_count = 3 after 12 beats.
- Change amplitude from 0x08000 to 0x04000 during beat 2 of a 4-beat packet → beats 2–4 keep gain 1.0; beat 5 onward is scaled by 0.5.
- Random M_AXIS_TREADY (50 %), random S_AXIS_TVALID, 1000 beats → scoreboard matches the model bit-exact; output data held while stalled; no loss or duplication.
- Assert AXIS_ARESET mid-packet with the pipeline full → outputs clear immediately; first post-reset packet has full length with TLAST on beat BEATS_PER_PACKET.
